// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART transmit and receive sides: the transmitter
// FSM state encoding and the line-level / parity-type constants. Both
// directions import the parity constants from here so they stay in agreement.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if
// Groups the parallel request side and the serial/flow-control outputs of the
// UART transmitter.
//   P_DATA     : byte to transmit
//   Data_Valid : request strobe, honoured only while the transmitter is idle
//   PAR_EN     : 1 = append a parity bit
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   Prescale   : clock cycles per serial bit (0 behaves as 1)
//   TX_OUT     : serial line, idles high
//   Busy       : high for the whole frame, start bit through stop bit
// Modports: master = request source (register/FIFO side), slave = transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_parity_calc.sv
// uart_parity_calc
// Combinational parity generator shared by the transmit and receive sides, so
// the generated bit and the checked bit always follow the same rule.
//   data    : data word the parity covers
//   par_typ : PAR_EVEN (0) or PAR_ODD (1)
//   par_bit : bit that makes the total count of ones even (or odd)
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    assign par_bit = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// UART transmitter: serialises one latched byte as start bit, data LSB first,
// optional parity bit and stop bit, each bit held for eff_prescale clocks.
//   CLK : single clock
//   RST : synchronous, active-high reset (aborts any frame in flight)
//   bus : uart_tx_frame_if slave modport (request inputs, TX_OUT and Busy)
// TX_OUT and Busy are flops, loaded with the value of the state being entered.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_frame_if.slave bus
);
    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    tx_state_e                 state;
    logic [PRESCALE_WIDTH-1:0] presc_cnt;
    logic [PRESCALE_WIDTH-1:0] presc_reg;
    logic [PRESCALE_WIDTH-1:0] eff_prescale;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic [BIT_CNT_W-1:0]      bit_cnt_nxt;
    logic [DATA_WIDTH-1:0]     data_reg;
    logic                      par_en_reg;
    logic                      par_typ_reg;
    logic                      tx_reg;
    logic                      busy_reg;
    logic                      parity_bit;
    logic                      bit_end;

    // Parity is taken from the latched byte so live P_DATA cannot disturb it.
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_reg),
        .par_typ (par_typ_reg),
        .par_bit (parity_bit)
    );

    // A zero prescale would never reach its terminal count, so it runs as 1.
    assign eff_prescale = (bus.Prescale == '0) ? PRESCALE_WIDTH'(1) : bus.Prescale;
    assign bit_end      = (presc_cnt == presc_reg - PRESCALE_WIDTH'(1));
    assign bit_cnt_nxt  = bit_cnt + BIT_CNT_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            presc_cnt   <= '0;
            presc_reg   <= '0;
            bit_cnt     <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            tx_reg      <= LINE_IDLE;
            busy_reg    <= 1'b0;
        end else if (state == IDLE) begin
            presc_cnt <= '0;
            bit_cnt   <= '0;
            tx_reg    <= LINE_IDLE;
            busy_reg  <= 1'b0;
            if (bus.Data_Valid) begin
                data_reg    <= bus.P_DATA;
                par_en_reg  <= bus.PAR_EN;
                par_typ_reg <= bus.PAR_TYP;
                presc_reg   <= eff_prescale;
                state       <= START;
                tx_reg      <= START_BIT;
                busy_reg    <= 1'b1;
            end
        end else if (!bit_end) begin
            presc_cnt <= presc_cnt + PRESCALE_WIDTH'(1);
        end else begin
            // End of the current bit: wrap the counter and load the next bit.
            presc_cnt <= '0;
            case (state)
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tx_reg  <= data_reg[0];
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en_reg) begin
                            state  <= PARITY;
                            tx_reg <= parity_bit;
                        end else begin
                            state  <= STOP;
                            tx_reg <= STOP_BIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt_nxt;
                        tx_reg  <= data_reg[bit_cnt_nxt];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    tx_reg <= STOP_BIT;
                end
                default: begin
                    // STOP (or an illegal encoding) returns the line to idle.
                    state    <= IDLE;
                    tx_reg   <= LINE_IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX_OUT = tx_reg;
    assign bus.Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
// Self-checking bench for uart_tx_frame. A frame-level model turns every
// accepted request into a queue of per-cycle {TX_OUT, Busy} values; a compare
// process checks the DUT against it every cycle. Directed tests add literal
// expectations for frame contents, lengths and gaps.
module tb_uart_tx_frame;

    logic CLK;
    logic RST;

    uart_tx_frame_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

    uart_tx_frame #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic        checkEn = 1'b0;
    logic [1:0]  expQ[$];
    logic        expTx   = 1'b1;
    logic        expBusy = 1'b0;
    logic [63:0] capTx;
    int          capLen;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expands one request into its serial bit list, each bit repeated for the
    // effective prescale, followed by the mandatory idle cycle.
    function automatic void pushFrame(input logic [7:0] d, input logic pe,
                                      input logic pt, input logic [5:0] ps);
        int   eff;
        logic bits[$];
        eff = (ps == 6'd0) ? 1 : int'(ps);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < eff; k++) expQ.push_back({bits[i], 1'b1});
        expQ.push_back(2'b10);
    endfunction

    // Model: decides what the outputs must be during the cycle after each edge.
    always @(posedge CLK) begin
        logic [1:0] e;
        if (RST) begin
            expQ.delete();
            e = 2'b10;
        end else if (expQ.size() != 0) begin
            e = expQ.pop_front();
        end else if (bus.Data_Valid === 1'b1) begin
            pushFrame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP, bus.Prescale);
            e = expQ.pop_front();
        end else begin
            e = 2'b10;
        end
        {expTx, expBusy} = e;
    end

    always @(negedge CLK) begin
        if (checkEn)
            checkOutput("cycle", {62'd0, bus.TX_OUT, bus.Busy}, {62'd0, expTx, expBusy});
    end

    always @(negedge CLK) begin
        if (bus.Busy === 1'b1) begin
            capTx  = {capTx[62:0], bus.TX_OUT};
            capLen = capLen + 1;
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic pe,
                                 input logic pt, input logic [5:0] ps);
        @(negedge CLK);
        capTx          = '0;
        capLen         = 0;
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Prescale   = ps;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
    endtask

    task automatic waitFrameDone(input string name);
        int n;
        n = 0;
        while (bus.Busy !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (bus.Busy !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s start timeout: got Busy=%b required 1", name, bus.Busy);
            return;
        end
        n = 0;
        while (bus.Busy === 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (bus.Busy !== 1'b0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s end timeout: got Busy=%b required 0", name, bus.Busy);
        end
    endtask

    initial begin
        logic [21:0] bb;
        RST            = 1'b1;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd1;
        capTx          = '0;
        capLen         = 0;

        // Reset for two cycles, then twenty idle cycles
        @(posedge CLK);
        #1;
        checkEn = 1'b1;
        checkOutput("reset_state", {62'd0, bus.TX_OUT, bus.Busy}, 64'b10);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        checkOutput("idle_after_reset", {62'd0, bus.TX_OUT, bus.Busy}, 64'b10);

        // No parity, prescale 1
        applyStimulus(8'hA5, 1'b0, 1'b0, 6'd1);
        waitFrameDone("a5_nopar");
        checkOutput("a5_nopar_len", 64'(capLen), 64'd10);
        checkOutput("a5_nopar_bits", capTx, 64'b0101001011);

        // Even and odd parity
        applyStimulus(8'hA5, 1'b1, 1'b0, 6'd1);
        waitFrameDone("a5_even");
        checkOutput("a5_even_len", 64'(capLen), 64'd11);
        checkOutput("a5_even_bits", capTx, 64'b01010010101);

        applyStimulus(8'hA5, 1'b1, 1'b1, 6'd1);
        waitFrameDone("a5_odd");
        checkOutput("a5_odd_bits", capTx, 64'b01010010111);

        applyStimulus(8'h07, 1'b1, 1'b0, 6'd1);
        waitFrameDone("07_even");
        checkOutput("07_even_bits", capTx, 64'b01110000011);

        // Prescale scaling
        applyStimulus(8'h3C, 1'b1, 1'b0, 6'd4);
        waitFrameDone("3c_ps4");
        checkOutput("3c_ps4_len", 64'(capLen), 64'd44);
        checkOutput("3c_ps4_bits", capTx, 64'h000FFFF000F);

        applyStimulus(8'hA5, 1'b0, 1'b0, 6'd0);
        waitFrameDone("ps0");
        checkOutput("ps0_len", 64'(capLen), 64'd10);
        checkOutput("ps0_bits", capTx, 64'b0101001011);

        // Request while busy is ignored
        applyStimulus(8'h55, 1'b0, 1'b0, 6'd1);
        repeat (3) @(negedge CLK);
        bus.P_DATA     = 8'hFF;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        waitFrameDone("busy_ignore");
        checkOutput("busy_ignore_bits", capTx, 64'b0101010101);
        repeat (5) @(negedge CLK);
        checkOutput("busy_ignore_no_second", {62'd0, bus.TX_OUT, bus.Busy}, 64'b10);

        // Reset during data bit 3
        applyStimulus(8'hA5, 1'b1, 1'b1, 6'd1);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("rst_mid_frame", {62'd0, bus.TX_OUT, bus.Busy}, 64'b10);
        @(negedge CLK);
        RST = 1'b0;
        applyStimulus(8'hA5, 1'b0, 1'b0, 6'd1);
        waitFrameDone("after_rst");
        checkOutput("after_rst_bits", capTx, 64'b0101001011);

        // Data_Valid held high: frames separated by one idle cycle
        @(negedge CLK);
        bus.P_DATA     = 8'hA5;
        bus.PAR_EN     = 1'b0;
        bus.Prescale   = 6'd1;
        bus.Data_Valid = 1'b1;
        bb = '0;
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            bb = {bb[20:0], bus.Busy};
        end
        bus.Data_Valid = 1'b0;
        checkOutput("back_to_back_busy", 64'(bb), 64'(22'b1111111111011111111110));
        repeat (15) @(negedge CLK);
        checkOutput("back_to_back_end_idle", {62'd0, bus.TX_OUT, bus.Busy}, 64'b10);

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by %0t required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
